sys_update_sequencer: RTL and testbench
=======================================

Name: sys_update_sequencer

Overview:
- Sequences the remote-update / system-update core (S25FL128 boot-flash variant) on behalf of a single host command port.
- Converts host commands (read param, write param, watchdog kick, reconfigure) into correctly timed single-cycle strobes on the core.
- Waits on the core's busy, captures read data and returns one response per command.
- Sits between the system CPU register block and the update core; the core may be the real IP or the inert stand-in whose busy never rises.

Parameters:
- BUSY_RISE_WAIT, 4: cycles after a strobe to wait for ru_busy to rise; if it never rises, the operation counts as complete.
- BUSY_TIMEOUT, 4096: maximum cycles ru_busy may stay high before the command completes with rsp_err=1.
- RST_HOLD, 4: cycles ru_reset stays asserted after reset_n deasserts.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous assert, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  0=READ_PARAM, 1=WRITE_PARAM, 2=WDT_KICK, 3=RECONFIG.
- cmd_param  in  3  parameter select.
- cmd_source  in  2  read source select.
- cmd_wdata  in  24  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  29  captured ru_data_out; 0 for non-read ops.
- rsp_err  out  1  busy timeout occurred.
- ru_busy  in  1  core busy.
- ru_data_out  in  29  core read data.
- ru_param  out  3  param to core.
- ru_read_source  out  2  read source to core.
- ru_data_in  out  24  write data to core.
- ru_read_param  out  1  read strobe.
- ru_write_param  out  1  write strobe.
- ru_reset_timer  out  1  watchdog reset strobe.
- ru_reconfig  out  1  reconfigure strobe.
- ru_reset  out  1  active-high core reset.

Behaviour:
- Reset values:
  - All outputs 0, except ru_reset=1.
  - ru_reset stays 1 for RST_HOLD cycles after reset_n rises.
  - cmd_ready stays 0 until ru_reset is 0.
- States:
  - RST_HOLD_S → IDLE after the hold count expires.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op, param, source and wdata, then go to ISSUE.
  - ISSUE: ru_param, ru_read_source and ru_data_in are held from the latch (stable from ISSUE through completion). Exactly one strobe is high for exactly one cycle:
    - READ_PARAM → ru_read_param.
    - WRITE_PARAM → ru_write_param.
    - WDT_KICK → ru_reset_timer.
    - RECONFIG → ru_reconfig.
    - Next state is WAIT_RISE for all ops except RECONFIG.
  - WAIT_RISE: counts up to BUSY_RISE_WAIT.
    - ru_busy=1 → WAIT_FALL.
    - Count expires with busy low → COMPLETE.
  - WAIT_FALL: counts cycles while ru_busy=1.
    - ru_busy=0 → COMPLETE.
    - Count reaches BUSY_TIMEOUT → COMPLETE with err flag set.
  - COMPLETE: rsp_valid=1 for one cycle; rsp_data=ru_data_out sampled this cycle for READ_PARAM, otherwise 0; rsp_err=flag. Next state IDLE.
  - RECONFIG path: ISSUE → RECONF. RECONF is terminal: cmd_ready=0, no response; only reset_n exits it.
- Latency:
  - Minimum command-to-response with an inert core: 1 (ISSUE) + BUSY_RISE_WAIT + 1 (COMPLETE) cycles = 6 with defaults.
  - Back-to-back commands: next accept is possible in the cycle after COMPLETE.
- Boundaries:
  - ISSUE is entered only when ru_busy=0; if busy is high in IDLE, cmd_ready is 0.
  - Busy glitch high for one cycle is treated as rise then fall (completes normally).
  - reset_n low mid-operation: all strobes drop immediately (async), no response is emitted, ru_reset reasserts.
  - Commands are never queued; cmd_ready is low outside IDLE.

Optional Feature:
- Macro SYSUPD_AUTO_KICK_EN.
- Defined:
  - Adds parameter KICK_PERIOD (default 1_000_000) and a free-running counter.
  - When the counter expires and the FSM is IDLE with no cmd_valid, an internal WDT_KICK runs through the normal path with no host response.
  - A kick due while busy is deferred until IDLE; only one is pending at a time.
  - The host command wins on a same-cycle conflict.
- Undefined: no counter; watchdog kicks come from the host only.

Decomposition:
- Package sys_update_pkg holds:
  - op enum (READ_PARAM, WRITE_PARAM, WDT_KICK, RECONFIG);
  - FSM state enum;
  - width constants PARAM_W=3, SRC_W=2, DIN_W=24, DOUT_W=29.
- One sub-module, sys_update_rst_hold: reset_n async-assert / synchronous-deassert synchroniser plus RST_HOLD counter driving ru_reset.

Test Plan:
- Reset: reset_n low then high → ru_reset=1 for 4 cycles, cmd_ready rises on cycle 5, all strobes 0.
- Inert core (busy always 0): READ_PARAM param=3'd2 source=2'd1 → one ru_read_param pulse with ru_param=2, ru_read_source=1; rsp_valid 6 cycles after accept, rsp_data=0, rsp_err=0.
- Model core: busy high 2 cycles after strobe, for 10 cycles, data_out=29'h0ABCDEF → rsp_data=29'h0ABCDEF, rsp_err=0.
- Busy stuck high after WRITE_PARAM wdata=24'h123456 → ru_data_in=24'h123456 held; rsp_err=1 after 4096 busy cycles; cmd_ready returns.
- RECONFIG → ru_reconfig high exactly 1 cycle, cmd_ready stays 0, no rsp_valid; reset_n pulse restores IDLE.
- reset_n asserted during WAIT_FALL → strobes and rsp_valid stay 0, ru_reset=1 asynchronously; with SYSUPD_AUTO_KICK_EN and KICK_PERIOD=100, ru_reset_timer pulses every ~100 idle cycles.

Source files
------------

// File: rtl/sys_update_pkg.sv
// Shared types and widths for the system-update sequencer.
// Covers the host op codes, FSM states and core port widths.
package sys_update_pkg;

    localparam int PARAM_W = 3;
    localparam int SRC_W   = 2;
    localparam int DIN_W   = 24;
    localparam int DOUT_W  = 29;

    typedef enum logic [1:0] {
        READ_PARAM  = 2'd0,
        WRITE_PARAM = 2'd1,
        WDT_KICK    = 2'd2,
        RECONFIG    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        RST_HOLD_S = 3'd0,
        IDLE       = 3'd1,
        ISSUE      = 3'd2,
        WAIT_RISE  = 3'd3,
        WAIT_FALL  = 3'd4,
        COMPLETE   = 3'd5,
        RECONF     = 3'd6
    } state_e;

    // One-hot strobe vector {reconfig, reset_timer, write_param, read_param}
    function automatic logic [3:0] op_strobe(input op_e op);
        logic [3:0] strb;
        case (op)
            READ_PARAM:  strb = 4'b0001;
            WRITE_PARAM: strb = 4'b0010;
            WDT_KICK:    strb = 4'b0100;
            RECONFIG:    strb = 4'b1000;
            default:     strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sys_update_rst_hold.sv
// Core reset generator: async-assert / sync-deassert of i_rst_n, then ru_reset
// held for RST_HOLD cycles in total after i_rst_n rises (sync stages included).
module sys_update_rst_hold #(
    parameter int RST_HOLD = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_ru_reset
);

    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CNT    = (RST_HOLD > SYNC_STAGES) ? (RST_HOLD - SYNC_STAGES) : 1;
    localparam int HC_W        = $clog2(HOLD_CNT + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CNT);

    logic [1:0]      r_sync;
    logic [HC_W-1:0] r_cnt;
    logic            r_ru_reset;
    logic [HC_W-1:0] w_cnt_nxt;

    // Reset synchroniser
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    // Hold counter advance once the synchronised reset has released
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_sync[1] && (r_cnt != HOLD_LAST)) begin
            w_cnt_nxt = r_cnt + HC_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Hold counter and registered core reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= {HC_W{1'b0}};
            r_ru_reset <= 1'b1;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_ru_reset <= (w_cnt_nxt != HOLD_LAST);
        end
    end

    assign o_ru_reset = r_ru_reset;

endmodule

// File: rtl/sys_update_sequencer.sv
// Host-command sequencer for the remote/system-update core.
// Optional macro SYSUPD_AUTO_KICK_EN adds a periodic internal watchdog kick.
module sys_update_sequencer
    import sys_update_pkg::*;
#(
    parameter int BUSY_RISE_WAIT = 4,
    parameter int BUSY_TIMEOUT   = 4096,
    parameter int RST_HOLD       = 4
`ifdef SYSUPD_AUTO_KICK_EN
    , parameter int KICK_PERIOD  = 1_000_000
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [PARAM_W-1:0] cmd_param,
    input  logic [SRC_W-1:0]  cmd_source,
    input  logic [DIN_W-1:0]  cmd_wdata,
    output logic              rsp_valid,
    output logic [DOUT_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              ru_busy,
    input  logic [DOUT_W-1:0] ru_data_out,
    output logic [PARAM_W-1:0] ru_param,
    output logic [SRC_W-1:0]  ru_read_source,
    output logic [DIN_W-1:0]  ru_data_in,
    output logic              ru_read_param,
    output logic              ru_write_param,
    output logic              ru_reset_timer,
    output logic              ru_reconfig,
    output logic              ru_reset
);

    localparam int CNT_MAX = (BUSY_TIMEOUT > BUSY_RISE_WAIT) ? BUSY_TIMEOUT : BUSY_RISE_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(BUSY_RISE_WAIT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;
    op_e                r_op;
    op_e                w_op_sel;
    logic [PARAM_W-1:0] r_param;
    logic [SRC_W-1:0]   r_source;
    logic [DIN_W-1:0]   r_wdata;
    logic [3:0]         r_strb;
    logic               r_rsp_valid;
    logic [DOUT_W-1:0]  r_rsp_data;
    logic               r_rsp_err;
    logic               w_ru_reset;
    logic               w_idle_free;
    logic               w_host_acc;
    logic               w_kick_go;
    logic               w_rsp_suppress;

    sys_update_rst_hold #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_hold (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .o_ru_reset (w_ru_reset)
    );

    // A command may only start while the core is idle
    assign w_idle_free = (r_state == IDLE) && !ru_busy;
    assign w_host_acc  = cmd_valid && w_idle_free;
    assign w_op_sel    = w_host_acc ? op_e'(cmd_op) : WDT_KICK;

`ifdef SYSUPD_AUTO_KICK_EN
    localparam int KICK_W = $clog2(KICK_PERIOD + 1);
    localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_PERIOD - 1);

    logic [KICK_W-1:0] r_kick_cnt;
    logic              r_kick_pend;
    logic              r_internal;

    // Host command wins; a pending kick only goes when the port is quiet
    assign w_kick_go      = r_kick_pend && w_idle_free && !cmd_valid;
    assign w_rsp_suppress = r_internal;

    // Free-running kick timer with a single pending slot
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_kick_cnt  <= {KICK_W{1'b0}};
            r_kick_pend <= 1'b0;
            r_internal  <= 1'b0;
        end else begin
            if (r_kick_cnt == KICK_LAST) begin
                r_kick_cnt  <= {KICK_W{1'b0}};
                r_kick_pend <= 1'b1;
            end else begin
                r_kick_cnt <= r_kick_cnt + KICK_W'(1);
                if (w_kick_go) begin
                    r_kick_pend <= 1'b0;
                end else begin
                    r_kick_pend <= r_kick_pend;
                end
            end
            if (w_host_acc) begin
                r_internal <= 1'b0;
            end else if (w_kick_go) begin
                r_internal <= 1'b1;
            end else begin
                r_internal <= r_internal;
            end
        end
    end
`else
    assign w_kick_go      = 1'b0;
    assign w_rsp_suppress = 1'b0;
`endif

    // Next-state, wait counter and timeout flag
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            RST_HOLD_S: begin
                if (!w_ru_reset) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RST_HOLD_S;
                end
            end
            IDLE: begin
                if (w_host_acc || w_kick_go) begin
                    w_state_nxt = ISSUE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                w_cnt_nxt = {CNT_W{1'b0}};
                if (r_op == RECONFIG) begin
                    w_state_nxt = RECONF;
                end else begin
                    w_state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                // The cycle busy is first seen counts as busy cycle one
                if (ru_busy) begin
                    w_state_nxt = WAIT_FALL;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (r_cnt == RISE_LAST) begin
                    w_state_nxt = COMPLETE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WAIT_FALL: begin
                if (!ru_busy) begin
                    w_state_nxt = COMPLETE;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = COMPLETE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            COMPLETE: begin
                w_state_nxt = IDLE;
            end
            RECONF: begin
                w_state_nxt = RECONF;
            end
            default: begin
                w_state_nxt = RST_HOLD_S;
            end
        endcase
    end

    // FSM state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RST_HOLD_S;
            r_cnt   <= {CNT_W{1'b0}};
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Command latch; fields stay stable until the next accept
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= READ_PARAM;
            r_param  <= {PARAM_W{1'b0}};
            r_source <= {SRC_W{1'b0}};
            r_wdata  <= {DIN_W{1'b0}};
        end else if (w_host_acc) begin
            r_op     <= op_e'(cmd_op);
            r_param  <= cmd_param;
            r_source <= cmd_source;
            r_wdata  <= cmd_wdata;
        end else if (w_kick_go) begin
            r_op <= WDT_KICK;
        end else begin
            r_op <= r_op;
        end
    end

    // Single-cycle strobes, high exactly during ISSUE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_strb <= 4'b0000;
        end else if (w_host_acc || w_kick_go) begin
            r_strb <= op_strobe(w_op_sel);
        end else begin
            r_strb <= 4'b0000;
        end
    end

    // Response registers, loaded from the COMPLETE cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {DOUT_W{1'b0}};
            r_rsp_err   <= 1'b0;
        end else if ((r_state == COMPLETE) && !w_rsp_suppress) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= (r_op == READ_PARAM) ? ru_data_out : {DOUT_W{1'b0}};
            r_rsp_err   <= r_err;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {DOUT_W{1'b0}};
            r_rsp_err   <= 1'b0;
        end
    end

    assign cmd_ready      = w_idle_free;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;
    assign ru_param       = r_param;
    assign ru_read_source = r_source;
    assign ru_data_in     = r_wdata;
    assign ru_read_param  = r_strb[0];
    assign ru_write_param = r_strb[1];
    assign ru_reset_timer = r_strb[2];
    assign ru_reconfig    = r_strb[3];
    assign ru_reset       = w_ru_reset;

endmodule

// File: tb/tb_sys_update_sequencer.sv
// Directed bench for sys_update_sequencer: vector table with a small busy
// model, plus hand sequences for reset release, RECONFIG and mid-op reset.
module tb_sys_update_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_param;
    logic [1:0]  cmd_source;
    logic [23:0] cmd_wdata;
    logic        rsp_valid;
    logic [28:0] rsp_data;
    logic        rsp_err;
    logic        ru_busy;
    logic [28:0] ru_data_out;
    logic [2:0]  ru_param;
    logic [1:0]  ru_read_source;
    logic [23:0] ru_data_in;
    logic        ru_read_param;
    logic        ru_write_param;
    logic        ru_reset_timer;
    logic        ru_reconfig;
    logic        ru_reset;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  param;
        logic [1:0]  src;
        logic [23:0] wdata;
        int          d;
        int          len;
        logic [28:0] dout;
        logic [28:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    sys_update_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_param      (cmd_param),
        .cmd_source     (cmd_source),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .ru_busy        (ru_busy),
        .ru_data_out    (ru_data_out),
        .ru_param       (ru_param),
        .ru_read_source (ru_read_source),
        .ru_data_in     (ru_data_in),
        .ru_read_param  (ru_read_param),
        .ru_write_param (ru_write_param),
        .ru_reset_timer (ru_reset_timer),
        .ru_reconfig    (ru_reconfig),
        .ru_reset       (ru_reset)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {ru_reconfig, ru_reset_timer, ru_write_param, ru_read_param};
    endfunction

    // Returns at a negedge where cmd_ready is high (or after the bound expires)
    task automatic wait_ready(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    // Release reset and check the ru_reset / cmd_ready profile
    task automatic release_and_check(input string nm);
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            chk({nm, "_ru_reset"}, {31'd0, ru_reset}, {31'd0, (k < 4)});
            chk({nm, "_ready"}, {31'd0, cmd_ready}, {31'd0, (k == 5)});
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          stb_ok, stb_bad, hold_bad, rdy_bad, rsp_cnt, rsp_n;
        logic [3:0]  s;
        logic [28:0] data;
        logic        err;
        string       tag;
        tag = $sformatf("vec%0d", id);
        stb_ok = 0; stb_bad = 0; hold_bad = 0; rdy_bad = 0; rsp_cnt = 0; rsp_n = -1;
        data = 29'd0; err = 1'b0;
        wait_ready({tag, "_ready_wait"});
        cmd_valid   = 1'b1;
        cmd_op      = v.op;
        cmd_param   = v.param;
        cmd_source  = v.src;
        cmd_wdata   = v.wdata;
        ru_data_out = v.dout;
        ru_busy     = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clock);
            if (n == 0) cmd_valid = 1'b0;
            s = strobes();
            if (s[v.op]) begin
                if (n == 0) stb_ok++;
                else stb_bad++;
            end
            if ((s & ~(4'b0001 << v.op)) != 4'b0000) stb_bad++;
            if (ru_param !== v.param || ru_read_source !== v.src || ru_data_in !== v.wdata) hold_bad++;
            if (!rsp_valid && rsp_n < 0 && cmd_ready) rdy_bad++;
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_n < 0) begin
                    rsp_n = n;
                    data  = rsp_data;
                    err   = rsp_err;
                end
            end
            ru_busy = (v.len > 0) && (n >= v.d) && (n < v.d + v.len);
            if (rsp_n >= 0 && n > rsp_n && n >= v.d + v.len) break;
        end
        ru_busy = 1'b0;
        chk({tag, "_strobe_once"}, stb_ok, 32'd1);
        chk({tag, "_strobe_extra"}, stb_bad, 32'd0);
        chk({tag, "_fields_held"}, hold_bad, 32'd0);
        chk({tag, "_ready_low_busy"}, rdy_bad, 32'd0);
        chk({tag, "_rsp_count"}, rsp_cnt, 32'd1);
        chk({tag, "_latency"}, rsp_n, v.exp_lat);
        chk({tag, "_rsp_data"}, {3'd0, data}, {3'd0, v.exp_data});
        chk({tag, "_rsp_err"}, {31'd0, err}, {31'd0, v.exp_err});
        @(negedge clock);
        chk({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int rc_strb, rc_first, rc_rdy, rc_rsp;
        // op, param, src, wdata, busy delay, busy length, data_out, exp data, exp err, exp latency
        vecs[0] = '{2'd0, 3'd2, 2'd1, 24'h000000, 0, 0,    29'h0000000,  29'h0000000,  1'b0, 6};
        vecs[1] = '{2'd0, 3'd5, 2'd2, 24'h00F00D, 2, 10,   29'h0ABCDEF,  29'h0ABCDEF,  1'b0, 14};
        vecs[2] = '{2'd1, 3'd1, 2'd0, 24'hA5A5A5, 1, 1,    29'h1FFFFFFF, 29'h0000000,  1'b0, 4};
        vecs[3] = '{2'd2, 3'd0, 2'd3, 24'h000000, 4, 3,    29'h0000155,  29'h0000000,  1'b0, 9};
        vecs[4] = '{2'd0, 3'd7, 2'd3, 24'hFFFFFF, 5, 3,    29'h1234567,  29'h1234567,  1'b0, 6};
        vecs[5] = '{2'd1, 3'd4, 2'd1, 24'h123456, 1, 4100, 29'h0000000,  29'h0000000,  1'b1, 4098};
        vecs[6] = '{2'd0, 3'd0, 2'd0, 24'h5A5A5A, 1, 3,    29'h1FFFFFFF, 29'h1FFFFFFF, 1'b0, 6};

        reset_n     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_param   = 3'd0;
        cmd_source  = 2'd0;
        cmd_wdata   = 24'd0;
        ru_busy     = 1'b0;
        ru_data_out = 29'd0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ru_reset", {31'd0, ru_reset}, 32'd1);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_strobes", {28'd0, strobes()}, 32'd0);
        chk("rst_rsp", {2'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        chk("rst_fields", {3'd0, ru_param, ru_read_source, ru_data_in}, 32'd0);
        release_and_check("rel0");

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // RECONFIG: one strobe, then terminal with no response
        wait_ready("rc_ready_wait");
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        rc_strb = 0; rc_first = 0; rc_rdy = 0; rc_rsp = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (n == 0) cmd_valid = 1'b0;
            if (ru_reconfig) begin
                rc_strb++;
                if (n == 0) rc_first = 1;
            end
            if (cmd_ready) rc_rdy++;
            if (rsp_valid) rc_rsp++;
        end
        chk("rc_strobe_cnt", rc_strb, 32'd1);
        chk("rc_strobe_first", rc_first, 32'd1);
        chk("rc_ready_low", rc_rdy, 32'd0);
        chk("rc_no_rsp", rc_rsp, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rc_async_reset", {31'd0, ru_reset}, 32'd1);
        @(negedge clock);
        release_and_check("rel1");

        // Reset in WAIT_FALL: everything drops at once, no response afterwards
        wait_ready("mid_ready_wait");
        cmd_valid   = 1'b1;
        cmd_op      = 2'd0;
        cmd_param   = 3'd6;
        ru_data_out = 29'h0DEAD;
        for (int n = 0; n <= 5; n++) begin
            @(negedge clock);
            if (n == 0) cmd_valid = 1'b0;
            ru_busy = (n >= 1);
        end
        reset_n = 1'b0;
        #1;
        chk("mid_ru_reset", {31'd0, ru_reset}, 32'd1);
        chk("mid_strobes", {28'd0, strobes()}, 32'd0);
        chk("mid_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("mid_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clock);
        ru_busy = 1'b0;
        rc_rsp = 0;
        @(negedge clock);
        if (rsp_valid) rc_rsp++;
        release_and_check("rel2");
        if (rsp_valid) rc_rsp++;
        chk("mid_no_rsp", rc_rsp, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
